reduction_pipe: RTL and testbench
=================================

Name: reduction_pipe

Overview:
Parametrised, pipelined lane-sum reduction unit, generalising the 16-bit nibble-sum reduction used by the RED instruction. Each beat splits operands a and b into LANE_W-bit lanes and sums all 2*DATA_W/LANE_W lanes, with unsigned or signed lane interpretation. An optional running accumulator saturates at OUT_W. Sits behind the execute stage on a valid/ready handshake; throughput is one beat per cycle.

Parameters:
DATA_W, 16, width of each operand a and b; must be a multiple of LANE_W.
LANE_W, 4, width of one lane.
OUT_W, 16, result and accumulator width; must be at least LANE_W + clog2(2*DATA_W/LANE_W) + 1.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  input beat valid.
in_ready  out  1  unit can accept an input beat this cycle.
a  in  DATA_W  operand A lanes.
b  in  DATA_W  operand B lanes.
signed_mode  in  1  1 = lanes are two's complement; 0 = lanes are unsigned.
accum  in  1  1 = add beat sum to the accumulator; 0 = restart the accumulator with this beat.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
out  out  OUT_W  result: sign-extended in signed mode, zero-extended in unsigned mode.
out_ovf  out  1  this result was saturated.

Behaviour:
- Reset (async, immediate): s1_valid=0, out_valid=0, out=0, out_ovf=0, accumulator=0. in_ready=1 while rst is deasserted after reset.
- Transfer rules: input transfer when in_valid&&in_ready. Output transfer when out_valid&&out_ready.
- Stage 1 register: holds the exact sum of all a-lanes and all b-lanes, plus signed_mode and accum. Lanes are extended per signed_mode. Internal widths are exact, with no intermediate truncation.
- Stage 2 is the output register (out, out_ovf, out_valid).
- Advance rules:
  - out_adv = s1_valid && (!out_valid || out_ready).
  - in_ready = !s1_valid || out_adv; this is combinational from state and out_ready only, not from in_valid.
- On out_adv:
  - raw = (accum ? acc : 0) + beat_sum, computed exactly in OUT_W+1 or more bits, interpreted per the beat's signed_mode.
  - result = raw clamped to [0, 2^OUT_W-1] (unsigned) or [-2^(OUT_W-1), 2^(OUT_W-1)-1] (signed).
  - out_ovf = (result != raw).
  - acc <= result; out <= result; out_valid <= 1.
- When out_valid && out_ready && !out_adv: out_valid <= 0. out and out_ovf hold their last values.
- The accumulator updates exactly once per result, at out_adv. It never updates on stalls or on output transfer alone.
- Latency: input accepted at edge k gives out_valid=1 after edge k+1 when there is no stall, i.e. 2 register stages.
- Simultaneous: output transfer and out_adv in the same cycle load the new result; out_valid stays 1. Throughput is 1/cycle with out_ready=1.
- Backpressure: with out_ready=0, at most 2 beats are held (stage 1 plus output). in_ready then drops to 0. No beat is lost or duplicated, and order is preserved.
- Mode mixing: the accumulator is reinterpreted in the signed_mode of the current beat; there is no separate clear. accum=0 restarts.
- Reset mid-operation discards all in-flight beats and clears the accumulator.

Test Plan:
1. Unsigned (default parameters): a=16'hFFFF, b=16'hFFFF, accum=0, out_ready=1 -> out=16'h0078 (120) two edges later, out_ovf=0.
2. Signed: a=b=16'h8888 -> out=16'hFFC0 (-64). Then a=b=16'h7777 back-to-back -> out=16'h0038 (56) on the next cycle.
3. Accumulate: 5 beats of a=b=16'hFFFF, unsigned; first beat accum=0, rest accum=1 -> out sequence 120, 240, 360, 480, 600 on consecutive cycles.
4. Saturation, OUT_W=8:
   - Unsigned 3 beats of a=b=FFFF (accum 0,1,1) -> 120, 240, 255 with out_ovf=0,0,1.
   - Signed 3 beats of a=b=8888 -> -64, -128 (ovf=0), -128 (ovf=1).
5. Backpressure: hold out_ready=0 and offer 4 accumulating beats -> in_ready=0 after 2 accepted. Release out_ready -> the remaining 2 are accepted, and outputs appear in order with correct running sums and no duplicate accumulation.
6. Reset mid-flight: assert rst with s1_valid=1 and out_valid=1 -> out_valid=0, out=0, in_ready=1 immediately. A subsequent beat with accum=1 (a=b=FFFF) -> out=120.

Source files
------------

// File: rtl/reduction_pipe.sv
// Two-stage lane-sum reduction with a saturating running accumulator; one beat per cycle.
// Latency 2 cycles; with out_ready low it holds two beats, then in_ready drops.
module reduction_pipe #(
    parameter int DATA_W = 16,
    parameter int LANE_W = 4,
    parameter int OUT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              signed_mode,
    input  logic              accum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out,
    output logic              out_ovf
);
    localparam int NLANE = DATA_W / LANE_W;
    // One spare bit so an unsigned sum of all lanes still reads as non-negative.
    localparam int SUM_W = LANE_W + $clog2(2 * NLANE) + 1;
    localparam int RAW_W = OUT_W + 2;

    localparam logic signed [RAW_W-1:0] U_MAX = {2'b00, {OUT_W{1'b1}}};
    localparam logic signed [RAW_W-1:0] S_MAX = {3'b000, {(OUT_W-1){1'b1}}};
    localparam logic signed [RAW_W-1:0] S_MIN = {3'b111, {(OUT_W-1){1'b0}}};

    typedef struct packed {
        logic [SUM_W-1:0] sum;
        logic             signedMode;
        logic             accum;
    } stage1_t;

    stage1_t                  s1;
    logic                     s1Valid;
    logic [OUT_W-1:0]         acc;
    logic [SUM_W-1:0]         beatSum;
    logic                     outAdv;
    logic signed [RAW_W-1:0]  accExt;
    logic signed [RAW_W-1:0]  sumExt;
    logic signed [RAW_W-1:0]  raw;
    logic [OUT_W-1:0]         result;
    logic                     resultOvf;

    function automatic logic [SUM_W-1:0] extLane(input logic [LANE_W-1:0] lane, input logic sgn);
        return {{(SUM_W-LANE_W){lane[LANE_W-1] & sgn}}, lane};
    endfunction

    always_comb begin
        beatSum = '0;
        for (int i = 0; i < NLANE; i++) begin
            beatSum = beatSum + extLane(a[i*LANE_W +: LANE_W], signed_mode)
                              + extLane(b[i*LANE_W +: LANE_W], signed_mode);
        end
    end

    assign outAdv   = s1Valid && (!out_valid || out_ready);
    assign in_ready = !s1Valid || outAdv;

    // The held accumulator is reinterpreted in the signedness of the beat now leaving stage 1.
    always_comb begin
        accExt = '0;
        if (s1.accum) begin
            accExt = {{2{s1.signedMode & acc[OUT_W-1]}}, acc};
        end
        sumExt = {{(RAW_W-SUM_W){s1.sum[SUM_W-1]}}, s1.sum};
        raw    = accExt + sumExt;

        result    = raw[OUT_W-1:0];
        resultOvf = 1'b0;
        if (s1.signedMode) begin
            if (raw > S_MAX) begin
                result    = S_MAX[OUT_W-1:0];
                resultOvf = 1'b1;
            end else if (raw < S_MIN) begin
                result    = S_MIN[OUT_W-1:0];
                resultOvf = 1'b1;
            end
        end else begin
            if (raw[RAW_W-1]) begin
                result    = '0;
                resultOvf = 1'b1;
            end else if (raw > U_MAX) begin
                result    = U_MAX[OUT_W-1:0];
                resultOvf = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid   <= 1'b0;
            s1        <= '0;
            acc       <= '0;
            out       <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (in_ready) begin
                s1Valid <= in_valid;
            end
            if (in_valid && in_ready) begin
                s1 <= '{sum: beatSum, signedMode: signed_mode, accum: accum};
            end
            if (outAdv) begin
                acc       <= result;
                out       <= result;
                out_ovf   <= resultOvf;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_reduction_pipe.sv
// Directed vectors against a 16-bit and an 8-bit result instance sharing one input stream.
module tb_reduction_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic [15:0] a;
    logic [15:0] b;
    logic        signedMode;
    logic        accum;
    logic        outReady;

    logic        inReady16, outValid16, outOvf16;
    logic [15:0] out16;
    logic        inReady8, outValid8, outOvf8;
    logic [7:0]  out8;

    int nTests = 0;
    int nFail  = 0;

    always #5 clk = ~clk;

    reduction_pipe #(.DATA_W(16), .LANE_W(4), .OUT_W(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady16),
        .a(a), .b(b), .signed_mode(signedMode), .accum(accum),
        .out_valid(outValid16), .out_ready(outReady), .out(out16), .out_ovf(outOvf16)
    );

    reduction_pipe #(.DATA_W(16), .LANE_W(4), .OUT_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady8),
        .a(a), .b(b), .signed_mode(signedMode), .accum(accum),
        .out_valid(outValid8), .out_ready(outReady), .out(out8), .out_ovf(outOvf8)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] va, input logic [15:0] vb,
                         input logic sm, input logic ac);
        inValid    = 1'b1;
        a          = va;
        b          = vb;
        signedMode = sm;
        accum      = ac;
    endtask

    task automatic idle();
        inValid = 1'b0;
        a       = '0;
        b       = '0;
    endtask

    // 120 = eight unsigned lanes of 15; -64 = eight signed lanes of -8; 56 = eight lanes of 7.
    logic [15:0] accSeq16 [5] = '{16'd120, 16'd240, 16'd360, 16'd480, 16'd600};
    logic [7:0]  uSat8    [3] = '{8'h78, 8'hF0, 8'hFF};
    logic        uOvf8    [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0]  sSat8    [3] = '{8'hC0, 8'h80, 8'h80};
    logic        sOvf8    [3] = '{1'b0, 1'b0, 1'b1};

    initial begin
        rst        = 1'b1;
        outReady   = 1'b1;
        signedMode = 1'b0;
        accum      = 1'b0;
        idle();
        #12;
        checkVal("rst_out_valid", {31'd0, outValid16}, 32'd0);
        checkVal("rst_out", {16'd0, out16}, 32'd0);
        checkVal("rst_out_ovf", {31'd0, outOvf16}, 32'd0);
        rst = 1'b0;
        #1;
        checkVal("rst_in_ready", {31'd0, inReady16}, 32'd1);
        tick();

        // Unsigned single beat, two-cycle latency
        drive(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        tick();
        idle();
        checkVal("lat_not_yet", {31'd0, outValid16}, 32'd0);
        tick();
        checkVal("u1_valid", {31'd0, outValid16}, 32'd1);
        checkVal("u1_out", {16'd0, out16}, 32'h0078);
        checkVal("u1_ovf", {31'd0, outOvf16}, 32'd0);
        tick();
        checkVal("u1_drained", {31'd0, outValid16}, 32'd0);

        // Signed, back-to-back
        drive(16'h8888, 16'h8888, 1'b1, 1'b0);
        tick();
        drive(16'h7777, 16'h7777, 1'b1, 1'b0);
        tick();
        idle();
        checkVal("s_neg", {16'd0, out16}, 32'h0000FFC0);
        tick();
        checkVal("s_pos", {16'd0, out16}, 32'h0038);
        checkVal("s_pos_valid", {31'd0, outValid16}, 32'd1);
        tick();

        // Accumulate five beats at full throughput
        for (int i = 0; i < 5; i++) begin
            drive(16'hFFFF, 16'hFFFF, 1'b0, (i != 0));
            tick();
            if (i >= 1) checkVal($sformatf("acc_%0d", i - 1), {16'd0, out16}, {16'd0, accSeq16[i-1]});
        end
        idle();
        tick();
        checkVal("acc_4", {16'd0, out16}, {16'd0, accSeq16[4]});
        tick();

        // Saturation on the 8-bit instance, unsigned then signed
        for (int i = 0; i < 3; i++) begin
            drive(16'hFFFF, 16'hFFFF, 1'b0, (i != 0));
            tick();
            if (i >= 1) begin
                checkVal($sformatf("usat_%0d", i - 1), {24'd0, out8}, {24'd0, uSat8[i-1]});
                checkVal($sformatf("usat_ovf_%0d", i - 1), {31'd0, outOvf8}, {31'd0, uOvf8[i-1]});
            end
        end
        idle();
        tick();
        checkVal("usat_2", {24'd0, out8}, {24'd0, uSat8[2]});
        checkVal("usat_ovf_2", {31'd0, outOvf8}, {31'd0, uOvf8[2]});
        for (int i = 0; i < 3; i++) begin
            drive(16'h8888, 16'h8888, 1'b1, (i != 0));
            tick();
            if (i >= 1) begin
                checkVal($sformatf("ssat_%0d", i - 1), {24'd0, out8}, {24'd0, sSat8[i-1]});
                checkVal($sformatf("ssat_ovf_%0d", i - 1), {31'd0, outOvf8}, {31'd0, sOvf8[i-1]});
            end
        end
        idle();
        tick();
        checkVal("ssat_2", {24'd0, out8}, {24'd0, sSat8[2]});
        checkVal("ssat_ovf_2", {31'd0, outOvf8}, {31'd0, sOvf8[2]});
        tick();

        // Backpressure: two beats held, then release
        outReady = 1'b0;
        drive(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        checkVal("bp_rdy0", {31'd0, inReady16}, 32'd1);
        tick();
        drive(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        checkVal("bp_rdy1", {31'd0, inReady16}, 32'd1);
        tick();
        drive(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        checkVal("bp_full", {31'd0, inReady16}, 32'd0);
        checkVal("bp_hold_out", {16'd0, out16}, 32'd120);
        tick();
        tick();
        checkVal("bp_still_full", {31'd0, inReady16}, 32'd0);
        checkVal("bp_no_dup", {16'd0, out16}, 32'd120);
        checkVal("bp_valid", {31'd0, outValid16}, 32'd1);
        outReady = 1'b1;
        #1;
        checkVal("bp_release_rdy", {31'd0, inReady16}, 32'd1);
        tick();
        drive(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        checkVal("bp_out1", {16'd0, out16}, 32'd240);
        tick();
        idle();
        checkVal("bp_out2", {16'd0, out16}, 32'd360);
        tick();
        checkVal("bp_out3", {16'd0, out16}, 32'd480);
        tick();
        checkVal("bp_drained", {31'd0, outValid16}, 32'd0);

        // Reset with both stages occupied
        outReady = 1'b0;
        drive(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        tick();
        drive(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        tick();
        idle();
        checkVal("mid_full", {31'd0, inReady16}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        checkVal("mid_rst_valid", {31'd0, outValid16}, 32'd0);
        checkVal("mid_rst_out", {16'd0, out16}, 32'd0);
        checkVal("mid_rst_rdy", {31'd0, inReady16}, 32'd1);
        #3;
        rst      = 1'b0;
        outReady = 1'b1;
        tick();
        drive(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        tick();
        idle();
        tick();
        checkVal("post_rst_acc", {16'd0, out16}, 32'd120);
        checkVal("post_rst_valid", {31'd0, outValid16}, 32'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
